accum_readback: RTL
===================

Name: accum_readback

Overview:
- Clocked accumulator with a buffered read-back port. It returns the accumulator value to the ALU operand path.
- Write side: the ALU result path issues LOAD/ADD/CLEAR commands that update the accumulator register.
- Read side: a request snapshots the accumulator into a small FIFO. The FIFO presents entries to the ALU operand mux over a valid/ready handshake.
- It sits between the ALU result bus and the ALU operand-A input. It closes the loop that the write-only accumulator path leaves open.

Parameters:
- WIDTH, 16, data width of the accumulator and read data.
- DEPTH, 2, read-back FIFO entries; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write command strobe
- wr_op  input  2  00 NOP, 01 LOAD, 10 ADD, 11 CLEAR
- wr_data  input  WIDTH  operand for LOAD/ADD
- rd_req  input  1  snapshot request, one per asserted cycle
- rd_valid  output  1  FIFO head is valid
- rd_ready  input  1  consumer accepts head
- rd_data  output  WIDTH  FIFO head value
- acc_q  output  WIDTH  live accumulator value
- zero  output  1  acc_q == 0
- carry  output  1  carry-out of last ADD
- ovf  output  1  signed overflow of last ADD
- req_drop  output  1  sticky: a rd_req was lost because the FIFO was full

Behaviour:
- The interface uses one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - acc_q=0, carry=0, ovf=0, zero=1
  - FIFO empty, so rd_valid=0 and rd_data=0
  - req_drop=0
- Reset mid-operation discards all FIFO contents and pending commands in that cycle.
- Write commands are sampled on the rising edge when wr_en=1; results are visible the next cycle (1-cycle latency).
  - NOP: no change.
  - LOAD: acc<=wr_data, carry<=0, ovf<=0.
  - ADD: {carry,acc}<=acc+wr_data, an unsigned WIDTH+1 sum that wraps modulo 2^WIDTH.
  - ADD overflow: ovf<=1 iff both operands share a sign bit and the result sign differs.
  - CLEAR: acc, carry and ovf <=0.
- wr_en=0 holds all state. carry and ovf change only on ADD, LOAD or CLEAR.
- zero is combinational from the acc register.
- rd_req snapshot:
  - Captures the pre-update accumulator value, i.e. acc_q as it stands in that cycle, even if a write occurs in the same cycle.
  - The captured value enters the FIFO tail on that edge.
- FIFO:
  - count ranges 0..DEPTH, with wrap-around read/write pointers.
  - Push when rd_req=1 and (count<DEPTH, or count==DEPTH with a pop in the same cycle).
  - Pop when rd_valid=1 and rd_ready=1.
  - Simultaneous push and pop leaves count unchanged.
  - Push into an empty FIFO gives rd_valid=1 the next cycle: request-to-valid latency is 1 cycle.
- Full and not popping: rd_req is dropped, the FIFO is unchanged, and req_drop<=1. req_drop stays at 1 until rst.
- rd_valid=(count!=0). rd_data shows the head entry, driven from registered FIFO storage.
- While rd_valid=1 and rd_ready=0, rd_data and rd_valid hold stable.
- When the FIFO is empty, rd_data holds the last popped value, or 0 after reset. rd_ready is don't-care.
- rd_ready may be asserted without rd_valid; that is not a pop.

Test Plan:
- Reset, then LOAD 0x1234, then rd_req with rd_ready=1:
  - acc_q=0x1234 one cycle after the LOAD.
  - rd_valid=1 and rd_data=0x1234 one cycle after rd_req, popped that cycle.
  - zero=0.
- Accumulate with wrap: LOAD 0xFFFF, then ADD 0x0002 -> acc_q=0x0001, carry=1, ovf=0.
- Signed overflow: LOAD 0x7FFF, then ADD 0x0001 -> acc_q=0x8000, carry=0, ovf=1. A following CLEAR gives acc_q=0, zero=1, carry=0, ovf=0.
- Same-cycle snapshot: acc=0x0005; drive rd_req with ADD 0x0003 in the same cycle -> rd_data=0x0005 and acc_q=0x0008.
- Full FIFO, DEPTH=2, rd_ready=0:
  - Snapshots of 0x0A and 0x0B, then a third rd_req -> req_drop=1 and the FIFO holds 0x0A,0x0B.
  - Assert rd_ready with rd_req at 0x0C -> pop 0x0A and push 0x0C in the same cycle; count stays 2.
- Reset mid-stream: FIFO holding 2 entries, rst=1 with rd_req=1 and wr_en=1 (ADD) -> the next cycle shows rd_valid=0, acc_q=0, req_drop=0, rd_data=0.

Source files
------------

// File: rtl/accum_readback.sv
`default_nettype none
// ============================================================================
// Module   : accum_readback
// Purpose  : Accumulator (LOAD/ADD/CLEAR) with a snapshot FIFO that returns
//            accumulator values to the ALU operand path over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module accum_readback #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_op,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] acc_q,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             req_drop
);

    localparam int         c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_LOAD  = 2'b01;
    localparam logic [1:0] c_OP_ADD   = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic               r_ovf;
    logic               r_req_drop;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rd_data;

    logic [WIDTH:0]     w_sum;
    logic               w_add_ovf;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [c_PTR_W-1:0] w_rd_ptr_inc;
    logic [c_PTR_W-1:0] w_wr_ptr_inc;
    logic [WIDTH-1:0]   w_head_n;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_sum        = {1'b0, r_acc} + {1'b0, wr_data};
    assign w_add_ovf    = (r_acc[WIDTH-1] == wr_data[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_pop        = rd_valid && rd_ready;
    assign w_push       = rd_req && (!w_full || w_pop);
    assign w_drop       = rd_req && w_full && !w_pop;
    assign w_rd_ptr_inc = ptr_inc(r_rd_ptr);
    assign w_wr_ptr_inc = ptr_inc(r_wr_ptr);

    // Next head: when the entry behind the head does not exist yet, it is the
    // value being pushed this cycle; when nothing remains, the last head holds.
    always_comb begin
        w_head_n = r_rd_data;
        if (w_pop) begin
            if (r_count > c_CNT_W'(1)) begin
                w_head_n = r_mem[w_rd_ptr_inc];
            end else if (w_push) begin
                w_head_n = r_acc;
            end
        end else if ((r_count == '0) && w_push) begin
            w_head_n = r_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (wr_en) begin
            case (wr_op)
                c_OP_NOP: ;
                c_OP_LOAD: begin
                    r_acc   <= wr_data;
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                end
                c_OP_ADD: begin
                    r_acc   <= w_sum[WIDTH-1:0];
                    r_carry <= w_sum[WIDTH];
                    r_ovf   <= w_add_ovf;
                end
                c_OP_CLEAR: begin
                    r_acc   <= '0;
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The snapshot uses r_acc before this edge's write takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_req_drop <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_acc;
                r_wr_ptr        <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_rd_data <= w_head_n;
            if (w_drop) begin
                r_req_drop <= 1'b1;
            end
        end
    end

    assign rd_valid = (r_count != '0);
    assign rd_data  = r_rd_data;
    assign acc_q    = r_acc;
    assign zero     = (r_acc == '0);
    assign carry    = r_carry;
    assign ovf      = r_ovf;
    assign req_drop = r_req_drop;

endmodule
`default_nettype wire
